// File: rtl/skeleton_bus_arbiter_pkg.sv
// Shared constants, types and address decode for the skeleton bus arbiter.
// Holds the skeleton address map and the arbiter FSM state type.
package skeleton_bus_arbiter_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 2;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int MIDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam int SLV_USB  = 0;
  localparam int SLV_TRAM = 1;

  localparam logic [ADDR_W-1:0] USB_IFACE_OFFSET = 16'd35840;
  localparam logic [ADDR_W-1:0] USB_IFACE_SIZE   = 16'd1024;
  localparam logic [ADDR_W-1:0] TEST_RAM_OFFSET  = 16'd8192;
  localparam logic [ADDR_W-1:0] TEST_RAM_SIZE    = 16'd256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              hit;
    logic [SIDX_W-1:0] idx;
    logic [ADDR_W-1:0] local_addr;
  } decode_t;

  // Subtract-then-compare keeps every comparison unsigned and ADDR_W wide.
  function automatic decode_t decode_addr(input logic [ADDR_W-1:0] a);
    decode_t d;
    d = '0;
    if ((a >= USB_IFACE_OFFSET) && ((a - USB_IFACE_OFFSET) < USB_IFACE_SIZE)) begin
      d.hit        = 1'b1;
      d.idx        = SIDX_W'(SLV_USB);
      d.local_addr = a - USB_IFACE_OFFSET;
    end else if ((a >= TEST_RAM_OFFSET) && ((a - TEST_RAM_OFFSET) < TEST_RAM_SIZE)) begin
      d.hit        = 1'b1;
      d.idx        = SIDX_W'(SLV_TRAM);
      d.local_addr = a - TEST_RAM_OFFSET;
    end
    return d;
  endfunction

endpackage

// File: rtl/skeleton_bus_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping.
// Produces the winning index and a valid flag; no state of its own.
module skeleton_bus_arbiter_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/skeleton_bus_arbiter.sv
// Round-robin arbiter that routes one single-word transaction at a time from
// NUM_MASTERS masters to the skeleton slave windows, with decode-miss and timeout errors.
module skeleton_bus_arbiter
  import skeleton_bus_arbiter_pkg::*;
#(
  parameter int AW      = ADDR_W,
  parameter int DW      = DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS*AW-1:0] m_addr,
  input  logic [NUM_MASTERS*DW-1:0] m_wdata,
  output logic [DW-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic                      m_err,
  output logic [NUM_SLAVES-1:0]     s_sel,
  output logic                      s_we,
  output logic [AW-1:0]             s_addr,
  output logic [DW-1:0]             s_wdata,
  input  logic [NUM_SLAVES*DW-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]     s_ack,
  output state_e                    dbg_state
);

  // Handshake: a master holds m_req (with we/addr/wdata stable) until it sees its
  // single-cycle m_ack; the selected slave holds s_ack for at least one cycle while
  // s_sel is high, and s_sel drops the cycle after that ack is seen.

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_e             state_q, state_d;
  logic [MIDX_W-1:0]  ptr_q, ptr_d;
  logic [MIDX_W-1:0]  gnt_q, gnt_d;
  logic [SIDX_W-1:0]  sidx_q, sidx_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [MIDX_W-1:0]  arb_idx;
  logic               arb_valid;
  decode_t            dec;

  skeleton_bus_arbiter_rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (MIDX_W)
  ) u_rr (
    .req       (m_req),
    .ptr       (ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sidx_d  = sidx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    dec     = decode_addr(m_addr[int'(arb_idx)*AW +: AW]);
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_idx;
          ptr_d = (arb_idx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : arb_idx + 1'b1;
          if (dec.hit) begin
            sidx_d  = dec.idx;
            we_d    = m_we[arb_idx];
            addr_d  = dec.local_addr;
            wdata_d = m_wdata[int'(arb_idx)*DW +: DW];
            cnt_d   = '0;
            state_d = XFER;
          end else begin
            // Decode miss completes without ever touching a slave.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      XFER: begin
        if (s_ack[sidx_q]) begin
          rdata_d = s_rdata[int'(sidx_q)*DW +: DW];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TO_LIM) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sidx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sidx_q  <= sidx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Selects and acks decode straight from registered state, so reset clears them at once.
  always_comb begin
    s_sel = '0;
    m_ack = '0;
    if (state_q == XFER) s_sel[sidx_q] = 1'b1;
    if (state_q == DONE) m_ack[gnt_q] = 1'b1;
  end

  assign s_we      = (state_q == XFER) && we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign m_rdata   = rdata_q;
  assign m_err     = (state_q == DONE) && err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_skeleton_bus_arbiter.sv
// Directed bench for skeleton_bus_arbiter: write/read routing, round-robin order,
// decode misses, slave timeout and asynchronous reset mid-transfer.
module tb_skeleton_bus_arbiter;
  import skeleton_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  m_req = '0;
  logic [3:0]  m_we = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [15:0] m_rdata;
  logic [3:0]  m_ack;
  logic        m_err;
  logic [1:0]  s_sel;
  logic        s_we;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_ack = '0;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  skeleton_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- checker and driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int m, input logic we, input logic [15:0] addr,
                            input logic [15:0] wd);
    m_we[m]            = we;
    m_addr[m*16 +: 16]  = addr;
    m_wdata[m*16 +: 16] = wd;
    m_req[m]           = 1'b1;
  endtask

  // Plays the slave side of one routed transaction. Starts at a negedge where the
  // request is already driven; ends at the negedge of the completion cycle.
  task automatic serve(input string tag, input int m, input logic [1:0] sel,
                       input logic [15:0] saddr, input logic we, input logic [15:0] wd,
                       input int lat, input int extra, input logic [15:0] rd);
    int n;
    int si;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_sel == 2'b00 && n < 8);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_sel"}, s_sel, sel);
    chk({tag, "_saddr"}, s_addr, saddr);
    chk({tag, "_swe"}, s_we, we);
    if (we) chk({tag, "_swdata"}, s_wdata, wd);
    chk({tag, "_noack"}, m_ack, 4'b0000);
    repeat (extra) @(negedge clk);
    if (extra > 0) chk({tag, "_hold"}, s_sel, sel);
    si = (sel == 2'b10) ? 1 : 0;
    s_rdata = '0;
    s_rdata[si*16 +: 16] = rd;
    s_ack = sel;
    @(negedge clk);
    chk({tag, "_ack"}, m_ack, 4'b0001 << m);
    chk({tag, "_err"}, m_err, 1'b0);
    chk({tag, "_seldrop"}, s_sel, 2'b00);
    if (!we) chk({tag, "_rdata"}, m_rdata, rd);
    s_ack = '0;
    m_req[m] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [3:0]  exp_m;
    int          miss_m[3];
    logic [15:0] miss_a[3];
    miss_m = '{1, 1, 3};
    miss_a = '{16'd8448, 16'd0, 16'd36864};

    repeat (3) @(negedge clk);
    chk("rst_m_ack", m_ack, 4'b0000);
    chk("rst_m_err", m_err, 1'b0);
    chk("rst_m_rdata", m_rdata, 16'h0000);
    chk("rst_s_sel", s_sel, 2'b00);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_s_addr", s_addr, 16'h0000);
    chk("rst_s_wdata", s_wdata, 16'h0000);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 1: master 0 writes 0x1234 to TEST_RAM local 5, slave acks on the second cycle.
    set_master(0, 1'b1, 16'd8197, 16'h1234);
    serve("t1", 0, 2'b10, 16'd5, 1'b1, 16'h1234, 1, 1, 16'h0000);
    @(negedge clk);
    chk("t1_pulse", m_ack, 4'b0000);
    chk("t1_idle", 32'(dbg_state), 32'(IDLE));

    // 2: master 2 reads the last USB_IFace word.
    set_master(2, 1'b0, 16'd36863, 16'h0000);
    serve("t2", 2, 2'b01, 16'd1023, 1'b0, 16'h0000, 1, 0, 16'hBEEF);
    @(negedge clk);

    // 4: decode misses complete in one cycle with err and zero data.
    for (int k = 0; k < 3; k++) begin
      set_master(miss_m[k], 1'b0, miss_a[k], 16'h0000);
      @(negedge clk);
      chk("t4_ack", m_ack, 4'b0001 << miss_m[k]);
      chk("t4_err", m_err, 1'b1);
      chk("t4_rdata", m_rdata, 16'h0000);
      chk("t4_sel", s_sel, 2'b00);
      m_req[miss_m[k]] = 1'b0;
      @(negedge clk);
      chk("t4_pulse", m_ack, 4'b0000);
      chk("t4_errclr", m_err, 1'b0);
    end

    // 3: all four request with the pointer at 0 -> served 0,1,2,3.
    for (int m = 0; m < 4; m++) begin
      set_master(m, 1'b0, 16'(8192 + m), 16'h0000);
      exp_q.push_back(4'(m));
    end
    for (int k = 0; k < 4; k++) begin
      exp_m = exp_q.pop_front();
      serve("t3_all", int'(exp_m), 2'b10, 16'(exp_m), 1'b0, 16'h0000,
            (k == 0) ? 1 : 2, 0, 16'hA000 + 16'(exp_m));
    end
    // Pointer is back at 0: masters 1 and 3 -> 1 first; then 0 joins with pointer at 2 -> 3 before 0.
    set_master(1, 1'b0, 16'd8209, 16'h0000);
    set_master(3, 1'b0, 16'd8211, 16'h0000);
    serve("t3_m1", 1, 2'b10, 16'd17, 1'b0, 16'h0000, 2, 0, 16'hB001);
    set_master(0, 1'b0, 16'd8208, 16'h0000);
    serve("t3_m3", 3, 2'b10, 16'd19, 1'b0, 16'h0000, 2, 0, 16'hB003);
    serve("t3_m0", 0, 2'b10, 16'd16, 1'b0, 16'h0000, 2, 0, 16'hB000);

    // 5: TEST_RAM never acks; a stray ack from USB_IFace must be ignored.
    set_master(2, 1'b1, 16'd8300, 16'h7777);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_sel == 2'b00 && n < 8);
    chk("t5_lat", n, 2);
    chk("t5_sel", s_sel, 2'b10);
    chk("t5_saddr", s_addr, 16'd108);
    n = 0;
    while (m_ack == 4'b0000 && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 100) s_ack = 2'b01;
      if (n == 101) begin
        s_ack = 2'b00;
        chk("t5_stray", s_sel, 2'b10);
      end
    end
    chk("t5_cycles", n, 256);
    chk("t5_ack", m_ack, 4'b0100);
    chk("t5_err", m_err, 1'b1);
    chk("t5_rdata", m_rdata, 16'h0000);
    chk("t5_seldrop", s_sel, 2'b00);
    m_req[2] = 1'b0;
    set_master(1, 1'b0, 16'd35840, 16'h0000);
    serve("t5_next", 1, 2'b01, 16'd0, 1'b0, 16'h0000, 2, 0, 16'h5A5A);

    // 6: reset during XFER of master 2, then masters 0 and 3 together -> 0 first.
    set_master(2, 1'b1, 16'd8392, 16'hCAFE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_sel == 2'b00 && n < 8);
    chk("t6_sel", s_sel, 2'b10);
    #2;
    rst   = 1'b1;
    m_req = '0;
    #1;
    chk("t6_rst_sel", s_sel, 2'b00);
    chk("t6_rst_ack", m_ack, 4'b0000);
    chk("t6_rst_rdata", m_rdata, 16'h0000);
    chk("t6_rst_saddr", s_addr, 16'h0000);
    chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_master(0, 1'b0, 16'd8193, 16'h0000);
    set_master(3, 1'b1, 16'd36000, 16'h4321);
    serve("t6_m0", 0, 2'b10, 16'd1, 1'b0, 16'h0000, 1, 0, 16'h0F0F);
    serve("t6_m3", 3, 2'b01, 16'd160, 1'b1, 16'h4321, 2, 2, 16'h0000);
    @(negedge clk);
    chk("t6_pulse", m_ack, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
